// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the display scheduler.
// Contents: scheduler state enum, display geometry constants, nibble select
// and top-non-zero-nibble helpers.
package disp_pkg;

   localparam int unsigned NDIGITS = 8;
   localparam int unsigned DIG_W   = 4;
   localparam int unsigned POS_W   = 3;
   localparam int unsigned WORD_W  = NDIGITS * DIG_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHOW   = 2'd1,
      LINGER = 2'd2
   } disp_state_e;

   // Nibble of word at digit position pos.
   function automatic logic [DIG_W-1:0] nibble_sel(input logic [WORD_W-1:0] word,
                                                    input logic [POS_W-1:0]  pos);
      return word[DIG_W*pos +: DIG_W];
   endfunction

   // Index of the most significant non-zero nibble; 0 for an all-zero word.
   function automatic logic [POS_W-1:0] top_nibble(input logic [WORD_W-1:0] word);
      logic [POS_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (word[DIG_W*i +: DIG_W] != '0) idx = POS_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester/display bundle of the display scheduler.
// master: requesters and display consumer (drive req/data_in, observe scan).
// slave : the scheduler (samples req/data_in, drives gnt and the digit scan).
interface display_scheduler_if
   import disp_pkg::*;
#(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]        req;
   logic [WORD_W*NREQ-1:0] data_in;
   logic [NREQ-1:0]        gnt;
   logic [POS_W-1:0]       pos;
   logic [DIG_W-1:0]       dig;
   logic                   point;
   logic                   off;
   logic                   frame_tick;

   modport master (
      output req, data_in,
      input  gnt, pos, dig, point, off, frame_tick
   );

   modport slave (
      input  req, data_in,
      output gnt, pos, dig, point, off, frame_tick
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest index at or above ptr wins, wrapping.
// Ports: req (requests), ptr (highest-priority index),
//        win_c (one-hot winner), valid_c (any request present).
module rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         win_c,
   output logic                    valid_c
);
   localparam int unsigned IDX_W = $clog2(NREQ);

   logic [IDX_W-1:0] idx;

   always_comb begin
      win_c   = '0;
      valid_c = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDX_W'((32'(ptr) + k) % NREQ);
         if (!valid_c && req[idx]) begin
            win_c[idx] = 1'b1;
            valid_c    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/display_scheduler.sv
// Shares the 8-digit seven-segment display among NREQ requesters with
// round-robin ownership, a minimum dwell in frames, and a controlled digit scan.
// Ports: clk, rst (sync, active-high), bus (slave modport: req/data_in in;
//        gnt/pos/dig/point/off/frame_tick out, all registered).
// Build option: DISP_LZB_EN enables leading-zero blanking.
module display_scheduler
   import disp_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned SCAN_DIV = 75000,
   parameter int unsigned DWELL    = 200
) (
   input logic                clk,
   input logic                rst,
   display_scheduler_if.slave bus
);
   localparam int unsigned IDX_W   = $clog2(NREQ);
   localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DWELL_W = $clog2(DWELL + 1);

   disp_state_e         state_q, state_nxt;
   logic [SCAN_W-1:0]   scan_q, scan_nxt;
   logic [POS_W-1:0]    pos_q, pos_nxt;
   logic                tick_q, wrap, slot_tc;
   logic [DWELL_W-1:0]  dwell_q, dwell_nxt;
   logic [IDX_W-1:0]    ptr_q, ptr_nxt, owner_q, owner_nxt, win_idx;
   logic [NREQ-1:0]     gnt_q, gnt_nxt, arb_req, win_oh;
   logic                win_valid, grant, lzb_blank;
   logic [WORD_W-1:0]   shadow_q, shadow_nxt;
   logic [DIG_W-1:0]    dig_q;
   logic                point_q, off_q;
   logic [WORD_W-1:0]   words [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign words[g] = bus.data_in[WORD_W*g +: WORD_W];
   end

   // The current owner is never a candidate, so LINGER hands off to someone else.
   assign arb_req = bus.req & ~gnt_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (arb_req),
      .ptr     (ptr_q),
      .win_c   (win_oh),
      .valid_c (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) win_idx = IDX_W'(i);
      end
   end

   // Digit-slot divider and position counter.
   always_comb begin
      slot_tc  = (scan_q == SCAN_W'(SCAN_DIV - 1));
      scan_nxt = slot_tc ? '0 : scan_q + SCAN_W'(1);
      pos_nxt  = slot_tc ? pos_q + POS_W'(1) : pos_q;
      wrap     = slot_tc && (pos_q == POS_W'(NDIGITS - 1));
   end

   // Ownership sequencer next-state.
   always_comb begin
      state_nxt  = state_q;
      owner_nxt  = owner_q;
      gnt_nxt    = gnt_q;
      shadow_nxt = shadow_q;
      dwell_nxt  = dwell_q;
      ptr_nxt    = ptr_q;
      grant      = 1'b0;
      unique case (state_q)
         IDLE: grant = win_valid;
         SHOW: begin
            if (bus.req[owner_q]) shadow_nxt = words[owner_q];
            if (wrap) begin
               if (dwell_q == DWELL_W'(DWELL - 1)) begin
                  dwell_nxt = DWELL_W'(DWELL);
                  state_nxt = LINGER;
               end else begin
                  dwell_nxt = dwell_q + DWELL_W'(1);
               end
            end
         end
         LINGER: begin
            grant = win_valid;
            if (!win_valid && bus.req[owner_q]) shadow_nxt = words[owner_q];
         end
         default: state_nxt = IDLE;
      endcase
      if (grant) begin
         state_nxt  = SHOW;
         owner_nxt  = win_idx;
         gnt_nxt    = win_oh;
         shadow_nxt = words[win_idx];
         dwell_nxt  = '0;
         ptr_nxt    = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end
   end

`ifdef DISP_LZB_EN
   assign lzb_blank = pos_nxt > top_nibble(shadow_nxt);
`else
   assign lzb_blank = 1'b0;
`endif

   // Display outputs are built from next-state values so they line up with pos.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         scan_q   <= '0;
         pos_q    <= '0;
         tick_q   <= 1'b0;
         dwell_q  <= '0;
         ptr_q    <= '0;
         owner_q  <= '0;
         gnt_q    <= '0;
         shadow_q <= '0;
         dig_q    <= '0;
         point_q  <= 1'b0;
         off_q    <= 1'b1;
      end else begin
         state_q  <= state_nxt;
         scan_q   <= scan_nxt;
         pos_q    <= pos_nxt;
         tick_q   <= wrap;
         dwell_q  <= dwell_nxt;
         ptr_q    <= ptr_nxt;
         owner_q  <= owner_nxt;
         gnt_q    <= gnt_nxt;
         shadow_q <= shadow_nxt;
         dig_q    <= nibble_sel(shadow_nxt, pos_nxt);
         point_q  <= (state_nxt != IDLE) && (pos_nxt == POS_W'(owner_nxt));
         off_q    <= (state_nxt == IDLE) || lzb_blank;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.pos        = pos_q;
   assign bus.dig        = dig_q;
   assign bus.point      = point_q;
   assign bus.off        = off_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (NREQ=4, SCAN_DIV=2, DWELL=2).
// Every cycle the DUT outputs are compared with a reference model built from
// elapsed time, a frame count per ownership and a round-robin search.
// Honours DISP_LZB_EN in the model when the build defines it.
module tb_display_scheduler;
   localparam int NREQ     = 4;
   localparam int SCAN_DIV = 2;
   localparam int DWELL    = 2;
   localparam int FRAME    = 8 * SCAN_DIV;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   string phase;

   display_scheduler_if #(.NREQ(NREQ)) bus ();

   display_scheduler #(
      .NREQ     (NREQ),
      .SCAN_DIV (SCAN_DIV),
      .DWELL    (DWELL)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   int          t;
   bit          owned;
   int          owner;
   logic [31:0] shadow;
   int          frames;
   int          rr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h (t=%0d, time %0t)",
                  phase, tag, got, exp, t, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] cand, input int start);
      int c;
      for (int k = 0; k < NREQ; k++) begin
         c = (start + k) % NREQ;
         if (cand[c]) return c;
      end
      return -1;
   endfunction

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_edge();
      logic [NREQ-1:0]    r;
      logic [NREQ-1:0]    others;
      logic [32*NREQ-1:0] d;
      int                 w;
      r = bus.req;
      d = bus.data_in;
      if (rst) begin
         t = 0; owned = 0; owner = 0; shadow = '0; frames = 0; rr = 0;
         return;
      end
      t++;
      w = -1;
      if (!owned) begin
         w = pick(r, rr);
      end else if (frames >= DWELL) begin
         others = r;
         others[owner] = 1'b0;
         w = pick(others, (owner + 1) % NREQ);
         if (w < 0 && r[owner]) shadow = d[32*owner +: 32];
      end else begin
         if (r[owner]) shadow = d[32*owner +: 32];
         if (t % FRAME == 0) frames++;
      end
      if (w >= 0) begin
         owned = 1; owner = w; shadow = d[32*w +: 32]; frames = 0; rr = (w + 1) % NREQ;
      end
   endtask

   task automatic compare();
      int p;
      bit blank;
`ifdef DISP_LZB_EN
      int msn;
`endif
      p = (t / SCAN_DIV) % 8;
      check("pos", 32'(bus.pos), p);
      check("frame_tick", 32'(bus.frame_tick), 32'(t > 0 && (t % FRAME) == 0));
      check("gnt", 32'(bus.gnt), owned ? (1 << owner) : 0);
      check("dig", 32'(bus.dig), (shadow >> (4 * p)) & 32'hF);
      check("point", 32'(bus.point), 32'(owned && p == owner));
      blank = !owned;
`ifdef DISP_LZB_EN
      msn = 0;
      for (int i = 0; i < 8; i++) if (((shadow >> (4 * i)) & 32'hF) != 0) msn = i;
      if (p > msn) blank = 1;
`endif
      check("off", 32'(bus.off), 32'(blank));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         model_edge();
         @(posedge clk);
         #1;
         compare();
      end
   endtask

   task automatic set_word(input int i, input logic [31:0] w);
      bus.data_in[32*i +: 32] = w;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      t = 0; owned = 0; owner = 0; shadow = '0; frames = 0; rr = 0;
      rst = 1'b1;
      bus.req = '0;
      bus.data_in = '0;

      phase = "reset_idle";
      do_reset();
      step(20);

      phase = "single_owner";
      set_word(1, 32'h12345678);
      bus.req = 4'b0010;
      step(40);

      phase = "rotation";
      do_reset();
      set_word(0, 32'h00000001); set_word(1, 32'h22222222);
      set_word(2, 32'h33330000); set_word(3, 32'h0000F004);
      bus.req = 4'b1111;
      step(200);

      phase = "live_then_frozen";
      do_reset();
      set_word(2, 32'hAAAA0000);
      bus.req = 4'b0100;
      step(10);
      set_word(2, 32'h0000BBBB);
      step(20);
      bus.req = 4'b0000;
      step(1);
      set_word(2, 32'h13572468);
      step(50);

      phase = "linger";
      do_reset();
      set_word(0, 32'h0BADBEEF); set_word(3, 32'h00C0FFEE);
      bus.req = 4'b0001;
      step(16);
      bus.req = 4'b0000;
      set_word(0, 32'h11111111);
      step(60);
      bus.req = 4'b1000;
      step(20);

      phase = "reset_mid_show";
      do_reset();
      bus.req = 4'b0010;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (owned && ((t / SCAN_DIV) % 8) == 5) break;
      end
      check("reached_pos5", 32'((t / SCAN_DIV) % 8), 5);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      bus.req = 4'b1001;
      step(12);

      phase = "lzb_words";
      do_reset();
      set_word(0, 32'h00000A30);
      bus.req = 4'b0001;
      step(20);
      set_word(0, 32'h00000000);
      step(20);
      set_word(0, 32'h80000000);
      step(20);

      phase = "random";
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0)
            set_word($urandom_range(0, NREQ - 1), $urandom >> $urandom_range(0, 31));
         rst = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
